id_stage_hazard: RTL and testbench

Parametrised successor to the combinational decode stage. It decodes one ARM-subset instruction per cycle, reads operands from an internal register file with write-back bypass, and detects RAW hazards against in-flight EX/MEM destinations. It drives a registered ID/EX bundle through a valid/ready handshake with flush support. It sits between IF and EX, absorbs the ID/EX pipeline register, and exports a saturating stall counter.

---
 rtl/id_pkg.sv | 94 +++++++++
 rtl/id_regfile.sv | 36 +++
 rtl/id_stage_hazard.sv | 198 +++++++++++++++++++
 tb/tb_id_stage_hazard.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared encodings for the ID stage: instruction modes, data-processing
// opcodes, EX command codes, condition codes and control-bundle layout.
package id_pkg;

    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10,
        MODE_UND = 2'b11
    } mode_e;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_EOR = 4'b0001,
        OP_SUB = 4'b0010,
        OP_ADD = 4'b0100,
        OP_ADC = 4'b0101,
        OP_SBC = 4'b0110,
        OP_TST = 4'b1000,
        OP_CMP = 4'b1010,
        OP_ORR = 4'b1100,
        OP_MOV = 4'b1101,
        OP_MVN = 4'b1111
    } opcode_e;

    typedef enum logic [3:0] {
        EX_NOP = 4'b0000,
        EX_MOV = 4'b0001,
        EX_ADD = 4'b0010,
        EX_ADC = 4'b0011,
        EX_SUB = 4'b0100,
        EX_SBC = 4'b0101,
        EX_AND = 4'b0110,
        EX_ORR = 4'b0111,
        EX_EOR = 4'b1000,
        EX_MVN = 4'b1001
    } ex_cmd_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Control bundle: {S, B, EX_CMD[3:0], MEM_W, MEM_R, WB_EN}
    localparam int unsigned CTRL_W       = 9;
    localparam int unsigned CTRL_S       = 8;
    localparam int unsigned CTRL_B       = 7;
    localparam int unsigned CTRL_EXC_LSB = 3;
    localparam int unsigned CTRL_MEM_W   = 2;
    localparam int unsigned CTRL_MEM_R   = 1;
    localparam int unsigned CTRL_WB_EN   = 0;

    // Flags are {N,Z,C,V}; the reserved 1111 encoding never executes.
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return c;
            COND_CC: return ~c;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return c & ~z;
            COND_LS: return ~c | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            COND_AL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Two-read, one-write register file with same-cycle write-back bypass.
module id_regfile #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic [DATA_WIDTH-1:0] rdata2_o
);

    localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

    // Storage: cleared on reset, written on write-back enable
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see a write landing this same cycle
    always_comb begin
        rdata1_o = (we_i && (waddr_i == raddr1_i)) ? wdata_i : mem_q[raddr1_i];
        rdata2_o = (we_i && (waddr_i == raddr2_i)) ? wdata_i : mem_q[raddr2_i];
    end

endmodule

// File: rtl/id_stage_hazard.sv
// Decode stage with register read, RAW hazard stall, registered ID/EX
// bundle behind a valid/ready handshake, and a saturating stall counter.
module id_stage_hazard
    import id_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_ADDR_W = 4,
    parameter bit          FWD_EN     = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic [31:0]           instr_in,
    input  logic [3:0]            status_reg,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic [DATA_WIDTH-1:0] wb_value,
    input  logic                  ex_wb_en,
    input  logic                  ex_mem_r,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic                  out_imm,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_val_rn,
    output logic [DATA_WIDTH-1:0] out_val_rm,
    output logic [REG_ADDR_W-1:0] out_src1,
    output logic [REG_ADDR_W-1:0] out_src2,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [11:0]           out_shift_op,
    output logic [23:0]           out_simm,
    output logic [CNT_W-1:0]      stall_count
);

    logic [1:0]            mode;
    logic [3:0]            opcode;
    ex_cmd_e               ex_cmd;
    logic                  dp_known, dp_wb, is_str, is_mov_mvn;
    logic                  use_src1, use_src2, hazard, accept;
    logic [CTRL_W-1:0]     ctrl_dec, ctrl_d;
    logic [REG_ADDR_W-1:0] src1, src2, dest;
    logic [DATA_WIDTH-1:0] rn_val, rm_val;

    logic                  valid_q;
    logic [CTRL_W-1:0]     ctrl_q;
    logic                  imm_q;
    logic [DATA_WIDTH-1:0] pc_q, rn_q, rm_q;
    logic [REG_ADDR_W-1:0] src1_q, src2_q, dest_q;
    logic [11:0]           shift_q;
    logic [23:0]           simm_q;
    logic [CNT_W-1:0]      cnt_q;

    assign mode   = instr_in[27:26];
    assign opcode = instr_in[24:21];
    assign is_str = (mode == MODE_MEM) && !instr_in[20];
    assign src1   = instr_in[19:16];
    assign src2   = is_str ? instr_in[15:12] : instr_in[3:0];
    assign dest   = instr_in[15:12];

    // Data-processing opcode to EX command
    always_comb begin
        ex_cmd   = EX_NOP;
        dp_known = 1'b1;
        dp_wb    = 1'b1;
        case (opcode)
            OP_MOV:  ex_cmd = EX_MOV;
            OP_MVN:  ex_cmd = EX_MVN;
            OP_ADD:  ex_cmd = EX_ADD;
            OP_ADC:  ex_cmd = EX_ADC;
            OP_SUB:  ex_cmd = EX_SUB;
            OP_SBC:  ex_cmd = EX_SBC;
            OP_AND:  ex_cmd = EX_AND;
            OP_ORR:  ex_cmd = EX_ORR;
            OP_EOR:  ex_cmd = EX_EOR;
            OP_CMP:  begin ex_cmd = EX_SUB; dp_wb = 1'b0; end
            OP_TST:  begin ex_cmd = EX_AND; dp_wb = 1'b0; end
            default: dp_known = 1'b0;
        endcase
    end

    // Control bundle per instruction mode, gated by the condition check
    always_comb begin
        ctrl_dec = '0;
        case (mode)
            MODE_DP: begin
                if (dp_known) begin
                    ctrl_dec[CTRL_S]                = instr_in[20];
                    ctrl_dec[CTRL_EXC_LSB +: 4]     = ex_cmd;
                    ctrl_dec[CTRL_WB_EN]            = dp_wb;
                end
            end
            MODE_MEM: begin
                ctrl_dec[CTRL_EXC_LSB +: 4] = EX_ADD;
                ctrl_dec[CTRL_MEM_R]        = instr_in[20];
                ctrl_dec[CTRL_WB_EN]        = instr_in[20];
                ctrl_dec[CTRL_MEM_W]        = !instr_in[20];
            end
            MODE_BR:  ctrl_dec[CTRL_B] = 1'b1;
            default:  ctrl_dec = '0;
        endcase
        ctrl_d = cond_pass(instr_in[31:28], status_reg) ? ctrl_dec : '0;
    end

    id_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk_i    (clk),
        .rst_ni   (rst),
        .we_i     (wb_en),
        .waddr_i  (wb_dest),
        .wdata_i  (wb_value),
        .raddr1_i (src1),
        .raddr2_i (src2),
        .rdata1_o (rn_val),
        .rdata2_o (rm_val)
    );

    function automatic logic raw_match(input logic [REG_ADDR_W-1:0] r);
        logic load_use, any_raw;
        load_use = ex_wb_en & ex_mem_r & (ex_dest == r);
        any_raw  = (ex_wb_en & (ex_dest == r)) | (mem_wb_en & (mem_dest == r));
        return FWD_EN ? load_use : any_raw;
    endfunction

    // Hazard is independent of whether the condition passes
    always_comb begin
        is_mov_mvn = (mode == MODE_DP) && ((opcode == OP_MOV) || (opcode == OP_MVN));
        use_src1   = !(is_mov_mvn || (mode == MODE_BR));
        use_src2   = ((mode == MODE_DP) && !instr_in[25]) || is_str;
        hazard     = in_valid & ((use_src1 & raw_match(src1)) | (use_src2 & raw_match(src2)));
        in_ready   = !flush && !hazard && (!valid_q || out_ready);
        accept     = in_valid && in_ready;
    end

    // ID/EX register: flush beats load, load beats bubble, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            imm_q   <= 1'b0;
            pc_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            dest_q  <= '0;
            shift_q <= '0;
            simm_q  <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_d;
            imm_q   <= instr_in[25];
            pc_q    <= pc_in;
            rn_q    <= rn_val;
            rm_q    <= rm_val;
            src1_q  <= src1;
            src2_q  <= src2;
            dest_q  <= dest;
            shift_q <= instr_in[11:0];
            simm_q  <= instr_in[23:0];
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Saturating count of cycles lost to hazards
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (hazard && !flush && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid    = valid_q;
    assign out_ctrl     = ctrl_q;
    assign out_imm      = imm_q;
    assign out_pc       = pc_q;
    assign out_val_rn   = rn_q;
    assign out_val_rm   = rm_q;
    assign out_src1     = src1_q;
    assign out_src2     = src2_q;
    assign out_dest     = dest_q;
    assign out_shift_op = shift_q;
    assign out_simm     = simm_q;
    assign stall_count  = cnt_q;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Scoreboard bench for id_stage_hazard: stimulus pushes expected bundles,
// a negedge monitor pops and compares each bundle EX consumes.
module tb_id_stage_hazard;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [8:0]    ctrl;
        logic          imm;
        logic [DW-1:0] pc;
        logic [DW-1:0] rn;
        logic [DW-1:0] rm;
        logic [AW-1:0] src1;
        logic [AW-1:0] src2;
        logic [AW-1:0] dest;
        logic [11:0]   shift;
        logic [23:0]   simm;
    } bundle_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [DW-1:0] pc_in;
    logic [31:0]   instr_in;
    logic [3:0]    status_reg;
    logic          wb_en;
    logic [AW-1:0] wb_dest;
    logic [DW-1:0] wb_value;
    logic          ex_wb_en, ex_mem_r;
    logic [AW-1:0] ex_dest;
    logic          mem_wb_en;
    logic [AW-1:0] mem_dest;
    logic          flush;
    logic          out_valid, out_ready;
    logic [8:0]    out_ctrl;
    logic          out_imm;
    logic [DW-1:0] out_pc, out_val_rn, out_val_rm;
    logic [AW-1:0] out_src1, out_src2, out_dest;
    logic [11:0]   out_shift_op;
    logic [23:0]   out_simm;
    logic [CW-1:0] stall_count;

    int checks = 0;
    int errors = 0;
    bundle_t sb[$];
    bundle_t exp_b, act_b;

    id_stage_hazard #(
        .DATA_WIDTH (DW),
        .REG_ADDR_W (AW),
        .FWD_EN     (1'b1),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc_in        (pc_in),
        .instr_in     (instr_in),
        .status_reg   (status_reg),
        .wb_en        (wb_en),
        .wb_dest      (wb_dest),
        .wb_value     (wb_value),
        .ex_wb_en     (ex_wb_en),
        .ex_mem_r     (ex_mem_r),
        .ex_dest      (ex_dest),
        .mem_wb_en    (mem_wb_en),
        .mem_dest     (mem_dest),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ctrl     (out_ctrl),
        .out_imm      (out_imm),
        .out_pc       (out_pc),
        .out_val_rn   (out_val_rn),
        .out_val_rm   (out_val_rm),
        .out_src1     (out_src1),
        .out_src2     (out_src2),
        .out_dest     (out_dest),
        .out_shift_op (out_shift_op),
        .out_simm     (out_simm),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one instruction; it must be accepted at the next edge
    task automatic issue(input string name, input logic [31:0] ins, input logic [DW-1:0] pc,
                         input bit push, input bundle_t e);
        in_valid = 1'b1;
        instr_in = ins;
        pc_in    = pc;
        #1;
        chk({"rdy_", name}, 64'(in_ready), 64'd1);
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every bundle EX consumes is checked against the scoreboard
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            act_b = '{out_ctrl, out_imm, out_pc, out_val_rn, out_val_rm,
                      out_src1, out_src2, out_dest, out_shift_op, out_simm};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL bundle_unexpected: got pc=%0h ctrl=%0h expected none", out_pc, out_ctrl);
            end else begin
                exp_b = sb.pop_front();
                if (act_b !== exp_b) begin
                    errors++;
                    $display("FAIL bundle_pc%0h: got ctrl=%0h imm=%0h pc=%0h rn=%0h rm=%0h s1=%0h s2=%0h d=%0h sh=%0h si=%0h expected ctrl=%0h imm=%0h pc=%0h rn=%0h rm=%0h s1=%0h s2=%0h d=%0h sh=%0h si=%0h",
                             exp_b.pc, act_b.ctrl, act_b.imm, act_b.pc, act_b.rn, act_b.rm,
                             act_b.src1, act_b.src2, act_b.dest, act_b.shift, act_b.simm,
                             exp_b.ctrl, exp_b.imm, exp_b.pc, exp_b.rn, exp_b.rm,
                             exp_b.src1, exp_b.src2, exp_b.dest, exp_b.shift, exp_b.simm);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; pc_in = '0; instr_in = '0; status_reg = '0;
        wb_en = 1'b0; wb_dest = '0; wb_value = '0; ex_wb_en = 1'b0; ex_mem_r = 1'b0;
        ex_dest = '0; mem_wb_en = 1'b0; mem_dest = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_rn", 64'(out_val_rn), 64'd0);
        chk("rst_stall", 64'(stall_count), 64'd0);
        rst = 1'b1;

        // Preload R3 = 0x33
        wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'h33;
        @(posedge clk); #1;

        // ADD R1,R2,R3 while R2 <= 0x55 is written the same cycle
        wb_dest = 4'd2; wb_value = 32'h55;
        issue("add", 32'hE0821003, 32'h100, 1'b1,
              '{9'h011, 1'b0, 32'h100, 32'h55, 32'h33, 4'd2, 4'd3, 4'd1, 12'h003, 24'h821003});
        wb_en = 1'b0;

        // SUBS R4,R2,#5
        issue("subs", 32'hE2524005, 32'h104, 1'b1,
              '{9'h121, 1'b1, 32'h104, 32'h55, 32'h0, 4'd2, 4'd5, 4'd4, 12'h005, 24'h524005});

        // Load-use hazard on R2: one stalled cycle
        ex_wb_en = 1'b1; ex_mem_r = 1'b1; ex_dest = 4'd2;
        in_valid = 1'b1; instr_in = 32'hE0821003; pc_in = 32'h108;
        #1;
        chk("hz_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("hz_stall1", 64'(stall_count), 64'd1);
        // Non-load EX writer and MEM writer are forwarded: no stall
        ex_mem_r = 1'b0; mem_wb_en = 1'b1; mem_dest = 4'd2;
        issue("add_fwd", 32'hE0821003, 32'h108, 1'b1,
              '{9'h011, 1'b0, 32'h108, 32'h55, 32'h33, 4'd2, 4'd3, 4'd1, 12'h003, 24'h821003});
        chk("fwd_stall", 64'(stall_count), 64'd1);
        ex_wb_en = 1'b0; mem_wb_en = 1'b0;

        // ADDEQ with Z=0 fails (ctrl zero, still valid); with Z=1 passes
        status_reg = 4'b0000;
        issue("addeq_f", 32'h00821003, 32'h10C, 1'b1,
              '{9'h000, 1'b0, 32'h10C, 32'h55, 32'h33, 4'd2, 4'd3, 4'd1, 12'h003, 24'h821003});
        status_reg = 4'b0100;
        issue("addeq_t", 32'h00821003, 32'h110, 1'b1,
              '{9'h011, 1'b0, 32'h110, 32'h55, 32'h33, 4'd2, 4'd3, 4'd1, 12'h003, 24'h821003});
        status_reg = 4'b0000;

        // LDR R6,[R2,#8]; STR R3,[R2,#4]; B
        issue("ldr", 32'hE5926008, 32'h114, 1'b1,
              '{9'h013, 1'b0, 32'h114, 32'h55, 32'h0, 4'd2, 4'd8, 4'd6, 12'h008, 24'h926008});
        issue("str", 32'hE5823004, 32'h118, 1'b1,
              '{9'h014, 1'b0, 32'h118, 32'h55, 32'h33, 4'd2, 4'd3, 4'd3, 12'h004, 24'h823004});
        issue("b", 32'hEA000010, 32'h11C, 1'b1,
              '{9'h080, 1'b1, 32'h11C, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 12'h010, 24'h000010});

        // MOV R7,#0xFF ignores rn, so a load-use match on R0 must not stall
        ex_wb_en = 1'b1; ex_mem_r = 1'b1; ex_dest = 4'd0;
        issue("mov", 32'hE3A070FF, 32'h120, 1'b1,
              '{9'h009, 1'b1, 32'h120, 32'h0, 32'h0, 4'd0, 4'd15, 4'd7, 12'h0FF, 24'hA070FF});
        ex_wb_en = 1'b0; ex_mem_r = 1'b0;

        // CMP R2,R3
        issue("cmp", 32'hE1520003, 32'h124, 1'b1,
              '{9'h120, 1'b0, 32'h124, 32'h55, 32'h33, 4'd2, 4'd3, 4'd0, 12'h003, 24'h520003});

        // Drain, then back-pressure: ORR is loaded but never consumed
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue("orr", 32'hE1825003, 32'h200, 1'b0, '0);
        in_valid = 1'b1; instr_in = 32'hE0225003; pc_in = 32'h204;
        #1;
        chk("bp_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_pc", 64'(out_pc), 64'h200);
        chk("bp_ctrl", 64'(out_ctrl), 64'h039);

        // Flush with a concurrent hazard: bundle killed, counter untouched
        flush = 1'b1;
        instr_in = 32'hE0821003; pc_in = 32'h208;
        ex_wb_en = 1'b1; ex_mem_r = 1'b1; ex_dest = 4'd2;
        @(posedge clk); #1;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_stall", 64'(stall_count), 64'd1);
        flush = 1'b0;
        out_ready = 1'b1;

        // Held hazard for 2**CW+5 cycles: counter saturates
        repeat (10) @(posedge clk);
        #1;
        chk("sat_mid", 64'(stall_count), 64'd11);
        chk("sat_ready", 64'(in_ready), 64'd0);
        repeat (11) @(posedge clk);
        #1;
        chk("sat_max", 64'(stall_count), 64'hF);
        chk("sat_valid", 64'(out_valid), 64'd0);

        // Reset mid-stall clears everything
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst2_stall", 64'(stall_count), 64'd0);
        chk("rst2_valid", 64'(out_valid), 64'd0);
        rst = 1'b1; in_valid = 1'b0; ex_wb_en = 1'b0; ex_mem_r = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
